// File: rtl/fb_pkg.sv
// Shared types for the frame buffer controller: write-side FSM state encoding.
// Imported by frame_buffer_ctrl and fb_ram_dp.
package fb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_FULL = 2'd2
    } wstate_e;

endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
// Ports: clk, rst_n (read register only), we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module fb_ram_dp
    import fb_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 17,
    parameter int DEPTH = 19200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array is never reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output register resets to 0 and holds its value while re_i is low.
    // Reading in the same edge as a write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer with write-side frame FSM, sequential read scan and error flags.
// Ports: wr_sof/wr_valid/wr_data in; rd_sof/rd_en in; rd_data/rd_valid/rd_addr,
// frame_done, frame_ready, sof_err out. Macro FB_BYPASS_EN enables write-through.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 17,
    parameter int DEPTH = 19200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_sof,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_sof,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic          frame_done,
    output logic          frame_ready,
    output logic          sof_err
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    generate
        if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << AW)) begin : g_bad_depth
            $error("frame_buffer_ctrl: DEPTH must be in 1..2**AW");
        end
    endgenerate

    wstate_e       wst_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW-1:0] rd_base;
    logic          rd_valid_q;
    logic          frame_done_q;
    logic          frame_ready_q;
    logic          sof_err_q;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] ram_q;

    // Write port decode: outside W_FILL only a start-of-frame pixel is accepted.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        if (wr_valid) begin
            case (wst_q)
                W_FILL: begin
                    we    = 1'b1;
                    waddr = wr_sof ? '0 : wr_ptr_q;
                end
                default: begin
                    we = wr_sof;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q         <= W_IDLE;
            wr_ptr_q      <= '0;
            frame_done_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            sof_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            if (wr_valid) begin
                case (wst_q)
                    W_FILL: begin
                        if (wr_sof) begin
                            // Restart: abandon the partial frame.
                            sof_err_q <= 1'b1;
                            wr_ptr_q  <= ONE;
                        end else if (wr_ptr_q == LAST) begin
                            frame_done_q  <= 1'b1;
                            frame_ready_q <= 1'b1;
                            wr_ptr_q      <= '0;
                            wst_q         <= W_FULL;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + ONE;
                        end
                    end
                    default: begin
                        if (wr_sof) begin
                            wr_ptr_q <= ONE;
                            wst_q    <= W_FILL;
                        end
                    end
                endcase
            end
        end
    end

    assign rd_base  = rd_sof ? '0 : rd_ptr_q;
    assign rd_ptr_d = (rd_base == LAST) ? '0 : rd_base + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_d;
            end
        end
    end

    fb_ram_dp #(
        .DW   (DW),
        .AW   (AW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we),
        .waddr_i(waddr),
        .wdata_i(wr_data),
        .re_i   (rd_en),
        .raddr_i(rd_base),
        .rdata_o(ram_q)
    );

`ifdef FB_BYPASS_EN
    logic          byp_q;
    logic [DW-1:0] byp_data_q;

    // Selection is captured only on reads so rd_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else if (rd_en) begin
            byp_q      <= we && (waddr == rd_base);
            byp_data_q <= wr_data;
        end
    end

    assign rd_data = byp_q ? byp_data_q : ram_q;
`else
    assign rd_data = ram_q;
`endif

    assign rd_valid    = rd_valid_q;
    assign rd_addr     = rd_ptr_q;
    assign frame_done  = frame_done_q;
    assign frame_ready = frame_ready_q;
    assign sof_err     = sof_err_q;

endmodule
